// File: rtl/mips_multicycle_control.sv
// Multicycle MIPS main control FSM: sequences fetch/decode/execute/memory/writeback
// and steers datapath muxes and strobes from the registered state.
module mips_multicycle_control (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic       zero,
  input  logic       mem_ready,
  output logic [2:0] ALUOp,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] pc_src,
  output logic       pc_write,
  output logic       i_or_d,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       zero_ext,
  output logic       illegal_op,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,  S_DECODE = 4'd1,  S_MEMADR = 4'd2,  S_MEMRD = 4'd3,
    S_MEMWB  = 4'd4,  S_MEMWR  = 4'd5,  S_REXEC  = 4'd6,  S_RWB   = 4'd7,
    S_BRANCH = 4'd8,  S_IEXEC  = 4'd9,  S_IWB    = 4'd10, S_JUMP  = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_SLTIU = 6'b001011;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  state_t     state_q, state_d;
  logic [5:0] op_q;
  logic       pc_write_c, ir_write_c, mem_write_c, reg_write_c;

  // State and opcode latch; opcode captured only while decoding.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_FETCH;
      op_q    <= 6'd0;
    end else begin
      state_q <= state_d;
      if (state_q == S_DECODE) op_q <= opcode;
    end
  end

  // Next state and per-state outputs.
  always_comb begin
    state_d     = S_FETCH;
    ALUOp       = 3'b000;
    alu_src_a   = 1'b0;
    alu_src_b   = 2'b00;
    pc_src      = 2'b00;
    pc_write_c  = 1'b0;
    i_or_d      = 1'b0;
    mem_read    = 1'b0;
    mem_write_c = 1'b0;
    ir_write_c  = 1'b0;
    reg_write_c = 1'b0;
    reg_dst     = 1'b0;
    mem_to_reg  = 1'b0;
    zero_ext    = 1'b0;
    illegal_op  = 1'b0;
    case (state_q)
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        if (mem_ready) begin
          ir_write_c = 1'b1;
          pc_write_c = 1'b1;
          state_d    = S_DECODE;
        end else begin
          state_d = S_FETCH;
        end
      end
      S_DECODE: begin
        alu_src_b = 2'b11;
        case (opcode)
          OP_LW, OP_SW:    state_d = S_MEMADR;
          OP_RTYPE:        state_d = S_REXEC;
          OP_BEQ, OP_BNE:  state_d = S_BRANCH;
          OP_J:            state_d = S_JUMP;
          OP_ADDI, OP_ADDIU, OP_ANDI, OP_ORI, OP_SLTI, OP_SLTIU:
                           state_d = S_IEXEC;
          default: begin
            illegal_op = 1'b1;
            state_d    = S_FETCH;
          end
        endcase
      end
      S_MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        state_d   = (op_q == OP_LW) ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        mem_read = 1'b1;
        i_or_d   = 1'b1;
        state_d  = mem_ready ? S_MEMWB : S_MEMRD;
      end
      S_MEMWB: begin
        reg_write_c = 1'b1;
        mem_to_reg  = 1'b1;
      end
      S_MEMWR: begin
        mem_write_c = 1'b1;
        i_or_d      = 1'b1;
        state_d     = mem_ready ? S_FETCH : S_MEMWR;
      end
      S_REXEC: begin
        alu_src_a = 1'b1;
        ALUOp     = 3'b010;
        state_d   = S_RWB;
      end
      S_RWB: begin
        reg_write_c = 1'b1;
        reg_dst     = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a  = 1'b1;
        ALUOp      = 3'b001;
        pc_src     = 2'b01;
        pc_write_c = ((op_q == OP_BEQ) && zero) || ((op_q == OP_BNE) && !zero);
      end
      S_IEXEC, S_IWB: begin
        zero_ext = (op_q == OP_ANDI) || (op_q == OP_ORI) || (op_q == OP_SLTIU);
        if (state_q == S_IEXEC) begin
          alu_src_a = 1'b1;
          alu_src_b = 2'b10;
          case (op_q)
            OP_ANDI:           ALUOp = 3'b100;
            OP_ORI:            ALUOp = 3'b101;
            OP_SLTI, OP_SLTIU: ALUOp = 3'b110;
            default:           ALUOp = 3'b000;
          endcase
          state_d = S_IWB;
        end else begin
          reg_write_c = 1'b1;
        end
      end
      S_JUMP: begin
        pc_src     = 2'b10;
        pc_write_c = 1'b1;
      end
      default: state_d = S_FETCH;
    endcase
  end

  // Write strobes are suppressed for the whole time reset is held.
  assign pc_write  = pc_write_c  & ~reset;
  assign ir_write  = ir_write_c  & ~reset;
  assign mem_write = mem_write_c & ~reset;
  assign reg_write = reg_write_c & ~reset;
  assign state     = state_q;

endmodule

// File: tb/tb_mips_multicycle_control.sv
// Directed bench for mips_multicycle_control: walks each instruction class with
// hand-computed expected states and control values.
module tb_mips_multicycle_control;

  logic       clk = 1'b0;
  logic       reset, zero, mem_ready;
  logic [5:0] opcode;
  logic [2:0] ALUOp;
  logic       alu_src_a, pc_write, i_or_d, mem_read, mem_write, ir_write;
  logic       reg_write, reg_dst, mem_to_reg, zero_ext, illegal_op;
  logic [1:0] alu_src_b, pc_src;
  logic [3:0] state;

  int errors = 0;
  int checks = 0;
  logic saw_aluop3 = 1'b0;

  mips_multicycle_control dut (
    .clk(clk), .reset(reset), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .ALUOp(ALUOp), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .pc_src(pc_src),
    .pc_write(pc_write), .i_or_d(i_or_d), .mem_read(mem_read), .mem_write(mem_write),
    .ir_write(ir_write), .reg_write(reg_write), .reg_dst(reg_dst),
    .mem_to_reg(mem_to_reg), .zero_ext(zero_ext), .illegal_op(illegal_op),
    .state(state)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (ALUOp === 3'b011) saw_aluop3 = 1'b1;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; zero = 1'b0; mem_ready = 1'b1; opcode = 6'b000000;
    step(); step();
    chk("rst_state", 8'(state), 8'd0);
    chk("rst_pc_write", 8'(pc_write), 8'd0);
    chk("rst_ir_write", 8'(ir_write), 8'd0);
    reset = 1'b0; #1;

    // R-type
    chk("r_fetch_state", 8'(state), 8'd0);
    chk("r_fetch_mem_read", 8'(mem_read), 8'd1);
    chk("r_fetch_src_b", 8'(alu_src_b), 8'd1);
    chk("r_fetch_aluop", 8'(ALUOp), 8'd0);
    chk("r_fetch_ir_write", 8'(ir_write), 8'd1);
    chk("r_fetch_pc_write", 8'(pc_write), 8'd1);
    step();
    chk("r_decode_state", 8'(state), 8'd1);
    chk("r_decode_src_b", 8'(alu_src_b), 8'd3);
    chk("r_decode_illegal", 8'(illegal_op), 8'd0);
    step();
    chk("r_exec_state", 8'(state), 8'd6);
    chk("r_exec_aluop", 8'(ALUOp), 8'd2);
    chk("r_exec_src_a", 8'(alu_src_a), 8'd1);
    step();
    chk("r_wb_state", 8'(state), 8'd7);
    chk("r_wb_reg_write", 8'(reg_write), 8'd1);
    chk("r_wb_reg_dst", 8'(reg_dst), 8'd1);
    step();
    chk("r_back_fetch", 8'(state), 8'd0);

    // lw with three wait cycles in MEMRD; live opcode changed after decode
    opcode = 6'b100011;
    step();
    chk("lw_decode", 8'(state), 8'd1);
    step();
    chk("lw_memadr", 8'(state), 8'd2);
    chk("lw_memadr_src_b", 8'(alu_src_b), 8'd2);
    opcode = 6'b000000;
    mem_ready = 1'b0;
    step();
    for (int i = 0; i < 4; i++) begin
      chk("lw_memrd_state", 8'(state), 8'd3);
      chk("lw_memrd_i_or_d", 8'(i_or_d), 8'd1);
      if (i == 3) mem_ready = 1'b1;
      step();
    end
    chk("lw_memwb_state", 8'(state), 8'd4);
    chk("lw_memwb_mem_to_reg", 8'(mem_to_reg), 8'd1);
    chk("lw_memwb_reg_write", 8'(reg_write), 8'd1);
    chk("lw_memwb_reg_dst", 8'(reg_dst), 8'd0);
    step();
    chk("lw_back_fetch", 8'(state), 8'd0);

    // beq
    opcode = 6'b000100; zero = 1'b1;
    step(); step();
    chk("beq_state", 8'(state), 8'd8);
    chk("beq_taken_pc_write", 8'(pc_write), 8'd1);
    chk("beq_pc_src", 8'(pc_src), 8'd1);
    chk("beq_aluop", 8'(ALUOp), 8'd1);
    zero = 1'b0; #1;
    chk("beq_not_taken", 8'(pc_write), 8'd0);
    step();
    chk("beq_back_fetch", 8'(state), 8'd0);

    // bne
    opcode = 6'b000101; zero = 1'b1;
    step(); step();
    chk("bne_state", 8'(state), 8'd8);
    chk("bne_zero1_pc_write", 8'(pc_write), 8'd0);
    chk("bne_aluop", 8'(ALUOp), 8'd1);
    zero = 1'b0; #1;
    chk("bne_zero0_pc_write", 8'(pc_write), 8'd1);
    step();

    // ori
    opcode = 6'b001101;
    step(); step();
    chk("ori_state", 8'(state), 8'd9);
    chk("ori_aluop", 8'(ALUOp), 8'd5);
    chk("ori_zero_ext", 8'(zero_ext), 8'd1);
    step();
    chk("ori_iwb_state", 8'(state), 8'd10);
    chk("ori_iwb_zero_ext", 8'(zero_ext), 8'd1);
    chk("ori_iwb_reg_write", 8'(reg_write), 8'd1);
    step();

    // slti
    opcode = 6'b001010;
    step(); step();
    chk("slti_aluop", 8'(ALUOp), 8'd6);
    chk("slti_zero_ext", 8'(zero_ext), 8'd0);
    step(); step();
    chk("slti_back_fetch", 8'(state), 8'd0);

    // jump
    opcode = 6'b000010;
    step(); step();
    chk("j_state", 8'(state), 8'd11);
    chk("j_pc_src", 8'(pc_src), 8'd2);
    chk("j_pc_write", 8'(pc_write), 8'd1);
    step();

    // illegal opcode
    opcode = 6'b111111;
    step();
    chk("ill_decode_pulse", 8'(illegal_op), 8'd1);
    step();
    chk("ill_back_fetch", 8'(state), 8'd0);
    chk("ill_pulse_gone", 8'(illegal_op), 8'd0);

    // sw, reset asserted while waiting on memory
    opcode = 6'b101011;
    step(); step();
    mem_ready = 1'b0;
    step();
    chk("sw_memwr_state", 8'(state), 8'd5);
    chk("sw_memwr_strobe", 8'(mem_write), 8'd1);
    step();
    chk("sw_wait_state", 8'(state), 8'd5);
    reset = 1'b1; #1;
    chk("sw_reset_no_write", 8'(mem_write), 8'd0);
    step();
    chk("sw_reset_state", 8'(state), 8'd0);
    reset = 1'b0; #1;

    // FETCH holds while memory is not ready
    chk("fetch_hold_ir_write", 8'(ir_write), 8'd0);
    step();
    chk("fetch_hold_state", 8'(state), 8'd0);
    mem_ready = 1'b1;
    step();
    chk("fetch_release_state", 8'(state), 8'd1);

    chk("aluop_011_never", 8'(saw_aluop3), 8'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/mips_multicycle_control.md
MIPS_MULTICYCLE_CONTROL -- requirements
Module: mips_multicycle_control

Interface
REQ-001 SHALL have ports, one clock domain; reset is synchronous and active-high:
clk  in  1  rising-edge clock
reset  in  1  synchronous active-high reset
opcode  in  6  instruction register bits [31:26]
zero  in  1  ALU zero flag
mem_ready  in  1  memory completes the current read/write this cycle
ALUOp  out  3  operation class to ALU control unit
alu_src_a  out  1  0=PC, 1=reg A
alu_src_b  out  2  00=reg B, 01=const 4, 10=imm, 11=imm<<2
pc_src  out  2  00=ALU result, 01=ALUOut, 10=jump target
pc_write  out  1  PC load enable
i_or_d  out  1  0=PC addresses memory, 1=ALUOut
mem_read  out  1  memory read request
mem_write  out  1  memory write request
ir_write  out  1  instruction register load
reg_write  out  1  register file write
reg_dst  out  1  0=rt, 1=rd
mem_to_reg  out  1  0=ALUOut, 1=MDR
zero_ext  out  1  1=zero-extend immediate
illegal_op  out  1  one-cycle pulse on unsupported opcode
state  out  4  current state (debug)

Function
REQ-002 SHALL be a Moore FSM except pc_write, ir_write, illegal_op (Mealy, noted per state); every output not listed for a state is 0.
REQ-003 States/encodings: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, REXEC=6, RWB=7, BRANCH=8, IEXEC=9, IWB=10, JUMP=11; codes 12-15 SHALL go to FETCH next cycle with all outputs 0.
REQ-004 ALUOp encoding: 000 add, 001 sub, 010 R-type (funct decides), 100 andi, 101 ori, 110 slti/sltiu; 011 SHALL never be driven.
REQ-005 FETCH: mem_read=1, alu_src_b=01, ALUOp=000; hold while mem_ready=0; when mem_ready=1: ir_write=1, pc_write=1, next DECODE.
REQ-006 DECODE: alu_src_b=11, ALUOp=000; next by opcode: 100011/101011->MEMADR, 000000->REXEC, 000100/000101->BRANCH, 000010->JUMP, 001000/001001/001100/001101/001010/001011->IEXEC; any other: illegal_op=1, next FETCH.
REQ-007 MEMADR: alu_src_a=1, alu_src_b=10, ALUOp=000; next MEMRD if lw, MEMWR if sw.
REQ-008 MEMRD: mem_read=1, i_or_d=1; hold until mem_ready=1, then MEMWB.
REQ-009 MEMWB: reg_write=1, mem_to_reg=1, reg_dst=0; next FETCH.
REQ-010 MEMWR: mem_write=1, i_or_d=1; hold until mem_ready=1, then FETCH.
REQ-011 REXEC: alu_src_a=1, alu_src_b=00, ALUOp=010; next RWB. RWB: reg_write=1, reg_dst=1; next FETCH.
REQ-012 BRANCH: alu_src_a=1, alu_src_b=00, ALUOp=001, pc_src=01; pc_write=1 iff (beq and zero=1) or (bne and zero=0); next FETCH.
REQ-013 IEXEC: alu_src_a=1, alu_src_b=10; ALUOp=000 addi/addiu, 100 andi, 101 ori, 110 slti/sltiu; zero_ext=1 for andi/ori/sltiu; next IWB.
REQ-014 IWB: reg_write=1, reg_dst=0, mem_to_reg=0, zero_ext held as in IEXEC; next FETCH.
REQ-015 JUMP: pc_src=10, pc_write=1; next FETCH.
REQ-016 opcode SHALL be sampled in DECODE and latched; later states use the latched value, not the live input.
REQ-017 Latency without wait states: R/I-type 4 cycles, lw 5, sw 4, branch 3, jump 3, illegal 2.

Reset
REQ-018 reset=1 at a rising edge SHALL force state=FETCH and clear the latched opcode, overriding any transition incl. mid-handshake waits.
REQ-019 In the cycle after reset deasserts, outputs SHALL be FETCH values (mem_read=1, alu_src_b=01, ALUOp=000); no write strobe asserts while reset=1.

Verification
REQ-020 Reset, mem_ready=1, opcode=000000 -> states 0,1,6,7,0; ALUOp=010 in state 6; reg_write=1, reg_dst=1 in state 7.
REQ-021 lw (100011), mem_ready=0 for 3 cycles in MEMRD -> state 3 held 4 cycles, i_or_d=1 throughout, then state 4 with mem_to_reg=1, reg_write=1.
REQ-022 beq with zero=1 -> pc_write=1, pc_src=01 in state 8; bne with zero=1 -> pc_write=0; ALUOp=001 both.
REQ-023 ori (001101) -> state 9 ALUOp=101, zero_ext=1; slti (001010) -> ALUOp=110, zero_ext=0; 011 never observed on ALUOp over full run.
REQ-024 opcode=111111 -> illegal_op=1 for one cycle in DECODE, next state 0; reset asserted during MEMWR wait -> mem_write=0 and state=0 next cycle.
